// File: rtl/multi_channel_stall_monitor.sv
// Multi-channel stall monitor: per-channel IDLE/BUSY/TIMEOUT/ERROR watchdogs with
// first-error capture, saturating event count, acknowledgeable alarm and status LED.
module multi_channel_stall_monitor #(
  parameter int  NUM_CH         = 4,
  parameter int  CNT_W          = 16,
  parameter int  TIMEOUT_CYCLES = 1000,
  parameter int  BLINK_CYCLES   = 500,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] trigger,
  input  logic [NUM_CH-1:0] complete,
  input  logic [NUM_CH-1:0] err_detect,
  input  logic              ext_alarm,
  input  logic              manual_clear,
  input  logic              alarm_ack,
  output logic [NUM_CH-1:0] stall,
  output logic [NUM_CH-1:0] timeout,
  output logic [3:0]        err_code,
  output logic [CH_W-1:0]   err_ch,
  output logic [7:0]        err_count,
  output logic              status_led,
  output logic              alarm
);
  localparam int                 BLINK_W    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_ERROR   = 2'd3
  } ch_state_e;

  ch_state_e          state_q [NUM_CH];
  ch_state_e          state_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];
  logic               ext_q, ext_d;

  logic [NUM_CH-1:0]  stall_q, stall_d, timeout_q, timeout_d, err_view_q, err_view_d;
  logic               ext_view_q, ext_view_d;
  logic [3:0]         err_code_q, err_code_d;
  logic [CH_W-1:0]    err_ch_q, err_ch_d;
  logic [7:0]         err_count_q, err_count_d;
  logic               alarm_q, alarm_d, led_q, led_d, phase_q, phase_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

  logic [NUM_CH-1:0]  in_err_s, in_to_s, data_ev_s, to_ev_s;
  logic               ext_ev_s, any_ev_s;
  logic [3:0]         code_sel_s;
  logic [CH_W-1:0]    ch_sel_s;

  // Per-channel watchdog next state; manual_clear overrides everything.
  always_comb begin
    ext_d = manual_clear ? 1'b0 : (ext_q | ext_alarm);
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (trigger[i]) begin
            state_d[i] = ST_BUSY;
            cnt_d[i]   = '0;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (complete[i]) begin
            state_d[i] = ST_IDLE;
          end else if (err_detect[i]) begin
            state_d[i] = ST_ERROR;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_TIMEOUT;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        ST_TIMEOUT: begin
          if (complete[i]) begin
            state_d[i] = ST_IDLE;
          end else if (err_detect[i]) begin
            state_d[i] = ST_ERROR;
          end else begin
            state_d[i] = ST_TIMEOUT;
          end
        end
        ST_ERROR: state_d[i] = ST_ERROR;
        default:  state_d[i] = ST_IDLE;
      endcase
      if (manual_clear) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_d[i];
      end
    end
  end

  // Channel state and external-alarm flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      ext_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ext_q <= ext_d;
    end
  end

  // An event is a state newly entered, seen against the last registered view.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_err_s[i] = (state_q[i] == ST_ERROR);
      in_to_s[i]  = (state_q[i] == ST_TIMEOUT);
    end
    data_ev_s  = in_err_s & ~err_view_q;
    to_ev_s    = in_to_s & ~timeout_q;
    ext_ev_s   = ext_q & ~ext_view_q;
    any_ev_s   = (|data_ev_s) | (|to_ev_s) | ext_ev_s;
    code_sel_s = ext_ev_s ? 4'b0100 : 4'b0000;
    ch_sel_s   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (to_ev_s[i]) begin
        code_sel_s = 4'b0001;
        ch_sel_s   = CH_W'(i);
      end else begin
        code_sel_s = code_sel_s;
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (data_ev_s[i]) begin
        code_sel_s = 4'b0010;
        ch_sel_s   = CH_W'(i);
      end else begin
        code_sel_s = code_sel_s;
      end
    end
  end

  // Next values of the registered outputs, blink phase and views.
  always_comb begin
    stall_d     = in_to_s | in_err_s;
    timeout_d   = in_to_s;
    err_view_d  = in_err_s;
    ext_view_d  = ext_q;
    err_code_d  = err_code_q;
    err_ch_d    = err_ch_q;
    err_count_d = err_count_q;
    alarm_d     = alarm_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    led_d       = 1'b0;
    if (any_ev_s) begin
      alarm_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end else begin
        err_count_d = err_count_q;
      end
      if (err_code_q == 4'b0000) begin
        err_code_d = code_sel_s;
        err_ch_d   = ch_sel_s;
      end else begin
        err_code_d = err_code_q;
      end
    end else if (alarm_ack) begin
      alarm_d = 1'b0;
    end else begin
      alarm_d = alarm_q;
    end
    // Phase starts high on the first ERROR cycle and flips every BLINK_CYCLES.
    if (|in_err_s) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end else begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end
    if (|in_err_s) begin
      led_d = phase_d;
    end else if ((|in_to_s) || ext_q) begin
      led_d = 1'b1;
    end else begin
      led_d = 1'b0;
    end
    if (manual_clear) begin
      stall_d     = '0;
      timeout_d   = '0;
      err_view_d  = '0;
      ext_view_d  = 1'b0;
      err_code_d  = 4'b0000;
      err_ch_d    = '0;
      err_count_d = 8'd0;
      alarm_d     = 1'b0;
      blink_cnt_d = '0;
      phase_d     = 1'b1;
      led_d       = 1'b0;
    end else begin
      led_d = led_d;
    end
  end

  // Output and view registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q     <= '0;
      timeout_q   <= '0;
      err_view_q  <= '0;
      ext_view_q  <= 1'b0;
      err_code_q  <= 4'b0000;
      err_ch_q    <= '0;
      err_count_q <= 8'd0;
      alarm_q     <= 1'b0;
      led_q       <= 1'b0;
      phase_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else begin
      stall_q     <= stall_d;
      timeout_q   <= timeout_d;
      err_view_q  <= err_view_d;
      ext_view_q  <= ext_view_d;
      err_code_q  <= err_code_d;
      err_ch_q    <= err_ch_d;
      err_count_q <= err_count_d;
      alarm_q     <= alarm_d;
      led_q       <= led_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign stall      = stall_q;
  assign timeout    = timeout_q;
  assign err_code   = err_code_q;
  assign err_ch     = err_ch_q;
  assign err_count  = err_count_q;
  assign status_led = led_q;
  assign alarm      = alarm_q;

endmodule
